div_pipe_signed: RTL and testbench

- Fully pipelined integer divider producing quotient, remainder and a divide-by-zero flag.
- Successor to the shift/subtract divider: adds a signed mode, remainder output, valid/ready handshake with backpressure, a per-operation tag, and a configurable number of quotient bits per stage.
- Sits in datapath blocks needing one divide per cycle, such as normalisation and scaling.

---
 rtl/div_pipe_signed.sv | 176 +++++++++++++++++
 tb/tb_div_pipe_signed.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_pipe_signed.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : div_pipe_signed
// Description : Fully pipelined restoring divider with signed/unsigned mode,
//               quotient + remainder outputs, divide-by-zero flag, sideband
//               tag and valid/ready handshake. One operation per cycle.
//               Latency = WidthD0/BitsPerStage + 2 cycles when not stalled.
//               WidthD0 must be a multiple of BitsPerStage and WidthD0 must
//               be at least WidthD1.
// Ports       : clk, rst         clock, synchronous active-high reset
//               in_valid/ready   input handshake (in_ready = !stall)
//               a, b             dividend (WidthD0), divisor (WidthD1)
//               signed_mode      1 = two's-complement operands
//               in_tag           sideband tag returned with the result
//               out_valid/ready  output handshake
//               quotient         a / b   (truncated toward zero)
//               remainder        a % b   (sign of dividend)
//               div_zero         b was zero
//               out_tag          tag of the presented result
// Revision    : 1.0 - initial release
// ============================================================================
module div_pipe_signed #(
  parameter int WidthD0      = 20,
  parameter int WidthD1      = 16,
  parameter int BitsPerStage = 1,
  parameter int TagWidth     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WidthD0-1:0]  a,
  input  logic [WidthD1-1:0]  b,
  input  logic                signed_mode,
  input  logic [TagWidth-1:0] in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WidthD0-1:0]  quotient,
  output logic [WidthD1-1:0]  remainder,
  output logic                div_zero,
  output logic [TagWidth-1:0] out_tag
);

  localparam int NSTG = WidthD0 / BitsPerStage;

  // A stall freezes every stage at once; bubbles are never squeezed out.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Index 0 is the input stage, index k+1 is the output of iteration stage k.
  // The registered partial remainder is always below the divisor, so WidthD1
  // bits suffice between stages; the extra bit only exists mid-iteration.
  logic                s_v    [0:NSTG];
  logic [WidthD1-1:0]  s_rem  [0:NSTG];
  logic [WidthD0-1:0]  s_dq   [0:NSTG];  // remaining dividend | quotient bits
  logic [WidthD1-1:0]  s_div  [0:NSTG];
  logic                s_qneg [0:NSTG];
  logic                s_rneg [0:NSTG];
  logic                s_zero [0:NSTG];
  logic [TagWidth-1:0] s_tag  [0:NSTG];
  logic [WidthD1-1:0]  s_alo  [0:NSTG];  // raw low dividend bits for b == 0

  // --------------------------------------------------------------------------
  // Input stage: magnitudes and sign bookkeeping. Negating the most-negative
  // value yields the same bit pattern, which read as unsigned is the correct
  // magnitude.
  // --------------------------------------------------------------------------
  logic               a_neg;
  logic               b_neg;
  logic [WidthD0-1:0] a_mag;
  logic [WidthD1-1:0] b_mag;

  always_comb begin
    a_neg = signed_mode && a[WidthD0-1];
    b_neg = signed_mode && b[WidthD1-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_v[0] <= 1'b0;
    end else if (!stall) begin
      s_v[0]    <= in_valid;
      s_rem[0]  <= '0;
      s_dq[0]   <= a_mag;
      s_div[0]  <= b_mag;
      s_qneg[0] <= (a_neg ^ b_neg) && (b != '0);
      s_rneg[0] <= a_neg;
      s_zero[0] <= (b == '0);
      s_tag[0]  <= in_tag;
      s_alo[0]  <= a[WidthD1-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Iteration stages: restoring shift/subtract, BitsPerStage bits each, MSB
  // first. Quotient bits are shifted into the bottom of s_dq as the dividend
  // bits leave the top.
  // --------------------------------------------------------------------------
  genvar k;
  generate
    for (k = 0; k < NSTG; k++) begin : g_stage
      logic [WidthD1-1:0] nrem;
      logic [WidthD0-1:0] ndq;
      logic [WidthD1:0]   sh;
      logic               ge;

      always_comb begin
        nrem = s_rem[k];
        ndq  = s_dq[k];
        sh   = '0;
        ge   = 1'b0;
        for (int i = 0; i < BitsPerStage; i++) begin
          sh   = {nrem, ndq[WidthD0-1]};
          ge   = (sh >= {1'b0, s_div[k]});
          // When ge holds, the true difference is below the divisor, so the
          // low WidthD1 bits of the subtraction are exact.
          nrem = ge ? (sh[WidthD1-1:0] - s_div[k]) : sh[WidthD1-1:0];
          ndq  = {ndq[WidthD0-2:0], ge};
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s_v[k+1] <= 1'b0;
        end else if (!stall) begin
          s_v[k+1]    <= s_v[k];
          s_rem[k+1]  <= nrem;
          s_dq[k+1]   <= ndq;
          s_div[k+1]  <= s_div[k];
          s_qneg[k+1] <= s_qneg[k];
          s_rneg[k+1] <= s_rneg[k];
          s_zero[k+1] <= s_zero[k];
          s_tag[k+1]  <= s_tag[k];
          s_alo[k+1]  <= s_alo[k];
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output stage: sign correction, divide-by-zero override.
  // --------------------------------------------------------------------------
  logic [WidthD0-1:0] q_fin;
  logic [WidthD1-1:0] r_fin;

  always_comb begin
    q_fin = s_qneg[NSTG] ? -s_dq[NSTG] : s_dq[NSTG];
    r_fin = s_rneg[NSTG] ? -s_rem[NSTG] : s_rem[NSTG];
    if (s_zero[NSTG]) begin
      q_fin = '1;
      r_fin = s_alo[NSTG];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (!stall) begin
      out_valid <= s_v[NSTG];
      quotient  <= q_fin;
      remainder <= r_fin;
      div_zero  <= s_zero[NSTG];
      out_tag   <= s_tag[NSTG];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_pipe_signed.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_div_pipe_signed
// Description : Scoreboard bench for div_pipe_signed. Stimulus pushes the
//               expected result when an operation is accepted; a monitor
//               pops and compares whenever a result transfers. A second
//               instance with BitsPerStage=4 shares the inputs and is used
//               for its latency and result on a quiet pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_pipe_signed;

  localparam int WD0  = 20;
  localparam int WD1  = 16;
  localparam int BPS  = 1;
  localparam int TW   = 4;
  localparam int NSTG = WD0 / BPS;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic [WD0-1:0] a = '0;
  logic [WD1-1:0] b = '0;
  logic           signed_mode = 1'b0;
  logic [TW-1:0]  in_tag = '0;
  logic           out_ready = 1'b1;

  wire            in_ready, out_valid, div_zero;
  wire [WD0-1:0]  quotient;
  wire [WD1-1:0]  remainder;
  wire [TW-1:0]   out_tag;

  wire            in_ready4, out_valid4, div_zero4;
  wire [WD0-1:0]  quotient4;
  wire [WD1-1:0]  remainder4;
  wire [TW-1:0]   out_tag4;

  div_pipe_signed #(.WidthD0(WD0), .WidthD1(WD1), .BitsPerStage(BPS), .TagWidth(TW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .signed_mode(signed_mode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero), .out_tag(out_tag));

  div_pipe_signed #(.WidthD0(WD0), .WidthD1(WD1), .BitsPerStage(4), .TagWidth(TW)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .a(a), .b(b),
    .signed_mode(signed_mode), .in_tag(in_tag), .out_valid(out_valid4), .out_ready(1'b1),
    .quotient(quotient4), .remainder(remainder4), .div_zero(div_zero4), .out_tag(out_tag4));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [WD0-1:0] q;
    logic [WD1-1:0] r;
    logic           z;
    logic [TW-1:0]  t;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   passes = 0;
  bit   bp_en  = 1'b0;
  int   t_acc  = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: handshake rule, hold-while-stalled, scoreboard pop.
  res_t prev;
  bit   prev_stall = 1'b0;
  always @(negedge clk) begin
    res_t got;
    res_t e;
    got = {quotient, remainder, div_zero, out_tag};
    if (!rst) begin
      chk(in_ready == !(out_valid && !out_ready), "in_ready",
          64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (prev_stall)
        chk(out_valid && (got == prev), "stall_hold", 64'(got), 64'(prev));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_output", 64'(got), 64'(0));
        end else begin
          e = sb.pop_front();
          chk(got == e, "result", 64'(got), 64'(e));
        end
      end
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev       = got;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_en) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic [WD0-1:0] ai, input logic [WD1-1:0] bi, input bit sm,
                       input logic [TW-1:0] ti, input logic [WD0-1:0] eq,
                       input logic [WD1-1:0] er, input bit ez, input bit push);
    bit acc = 1'b0;
    int n   = 0;
    in_valid = 1'b1; a = ai; b = bi; signed_mode = sm; in_tag = ti;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc   = in_ready;
      t_acc = cyc;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk(1'b0, "accept_timeout", 64'(0), 64'(1));
    else if (push) sb.push_back({eq, er, ez, ti});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      tick();
      n++;
    end
    chk(sb.size() == 0, "drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat1, lat4, seen, aa, bb;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'(0));
    chk(quotient == '0,    "rst_quotient",  64'(quotient),  64'(0));
    chk(remainder == '0,   "rst_remainder", 64'(remainder), 64'(0));
    chk(div_zero == 1'b0,  "rst_div_zero",  64'(div_zero),  64'(0));
    chk(out_tag == '0,     "rst_out_tag",   64'(out_tag),   64'(0));
    chk(in_ready == 1'b1,  "rst_in_ready",  64'(in_ready),  64'(1));
    tick();

    // Latency on an empty pipe for both stage granularities.
    issue(20'h13880, 16'h0007, 1'b0, 4'd5, 20'h02CA4, 16'h0004, 1'b0, 1'b1);
    lat1 = -1; lat4 = -1;
    for (int n = 0; n < 60 && (lat1 < 0 || lat4 < 0); n++) begin
      @(negedge clk);
      if (out_valid4 && lat4 < 0) begin
        lat4 = cyc - t_acc;
        chk({quotient4, remainder4, div_zero4, out_tag4} == {20'h02CA4, 16'h0004, 1'b0, 4'd5},
            "bps4_result", 64'({quotient4, remainder4, div_zero4, out_tag4}),
            64'({20'h02CA4, 16'h0004, 1'b0, 4'd5}));
      end
      if (out_valid && lat1 < 0) lat1 = cyc - t_acc;
    end
    chk(lat1 == NSTG + 2, "latency_bps1", 64'(lat1), 64'(NSTG + 2));
    chk(lat4 == WD0 / 4 + 2, "latency_bps4", 64'(lat4), 64'(WD0 / 4 + 2));
    tick();
    drain();

    // Directed signed / unsigned / zero / overflow vectors, back-to-back.
    issue(20'h13880, 16'h0007, 1'b1, 4'd1,  20'h02CA4, 16'h0004, 1'b0, 1'b1);
    issue(20'hEC780, 16'h0007, 1'b1, 4'd2,  20'hFD35C, 16'hFFFC, 1'b0, 1'b1);
    issue(20'h13880, 16'hFFF9, 1'b1, 4'd3,  20'hFD35C, 16'h0004, 1'b0, 1'b1);
    issue(20'hEC780, 16'hFFF9, 1'b1, 4'd4,  20'h02CA4, 16'hFFFC, 1'b0, 1'b1);
    issue(20'hEC780, 16'hFFF9, 1'b0, 4'd5,  20'h0000E, 16'hC7E2, 1'b0, 1'b1);
    issue(20'h03039, 16'h0000, 1'b0, 4'd6,  20'hFFFFF, 16'h3039, 1'b1, 1'b1);
    issue(20'h03039, 16'h0000, 1'b1, 4'd7,  20'hFFFFF, 16'h3039, 1'b1, 1'b1);
    issue(20'hEC780, 16'h0000, 1'b1, 4'd8,  20'hFFFFF, 16'hC780, 1'b1, 1'b1);
    issue(20'h00064, 16'h0003, 1'b1, 4'd9,  20'h00021, 16'h0001, 1'b0, 1'b1);
    issue(20'h80000, 16'hFFFF, 1'b1, 4'd10, 20'h80000, 16'h0000, 1'b0, 1'b1);
    issue(20'h80000, 16'hFFFF, 1'b0, 4'd11, 20'h00008, 16'h0008, 1'b0, 1'b1);
    issue(20'hFFFF9, 16'h0002, 1'b1, 4'd12, 20'hFFFFD, 16'hFFFF, 1'b0, 1'b1);
    issue(20'h13880, 16'h8000, 1'b1, 4'd13, 20'hFFFFE, 16'h3880, 1'b0, 1'b1);
    drain();

    // Unsigned sweep of 80000 / b, back-to-back.
    for (int k = 1; k <= 4097; k++) begin
      bb = (k == 4097) ? 65535 : k;
      issue(WD0'(80000), WD1'(bb), 1'b0, TW'(k), WD0'(80000 / bb), WD1'(80000 % bb), 1'b0, 1'b1);
    end
    drain();

    // Backpressure: tags 0..15 with random out_ready.
    bp_en = 1'b1;
    for (int t = 0; t < 16; t++) begin
      aa = 5000 * t + 123;
      bb = t + 3;
      issue(WD0'(aa), WD1'(bb), 1'b0, TW'(t), WD0'(aa / bb), WD1'(aa % bb), 1'b0, 1'b1);
    end
    drain();
    bp_en = 1'b0;
    out_ready = 1'b1;
    tick();

    // Reset mid-flight: three ops accepted, fourth presented alongside rst.
    issue(20'h13880, 16'h0007, 1'b0, 4'd1, '0, '0, 1'b0, 1'b0);
    issue(20'h13880, 16'h0009, 1'b0, 4'd2, '0, '0, 1'b0, 1'b0);
    issue(20'h13880, 16'h000B, 1'b0, 4'd3, '0, '0, 1'b0, 1'b0);
    in_valid = 1'b1; a = 20'h13880; b = 16'h000D; in_tag = 4'd4;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid || out_valid4) seen++;
    end
    chk(seen == 0, "post_reset_quiet", 64'(seen), 64'(0));
    chk(in_ready == 1'b1, "post_reset_in_ready", 64'(in_ready), 64'(1));
    tick();

    issue(20'h13880, 16'h0007, 1'b0, 4'd14, 20'h02CA4, 16'h0004, 1'b0, 1'b1);
    drain();
    repeat (3) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
